vc_lock_allocator: RTL and testbench

- Next-generation allocator core for the router's VC-allocation and switch-allocation stages.
- Contains one round-robin arbiter per (output port, VC), each choosing among N input ports.
- Unlike the previous core, which held a grant only while the request stayed up, each arbiter locks on a packet until an explicit release (tail flit).
- Adds a bounded hold length, per-output on/off back-pressure that freezes arbiter state, and an optional registered grant stage.

---
 rtl/vc_lock_allocator.sv | 183 ++++++++++++++++++
 tb/tb_vc_lock_allocator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vc_lock_allocator.sv
// vc_lock_allocator: one round-robin arbiter per (output port, VC), each
// choosing among N input ports. A winner locks its arbiter until it sends a
// tail (release), drops its request, or exceeds MAX_HOLD cycles while someone
// else waits. A blocked arbiter (on_off) grants nothing and freezes its state.
//
// Handshake: request is level-sensitive and one-hot over outputs per (i,j).
// A grant in a cycle means that flit is transferred in that cycle. There is no
// separate ready; on_off acts as the per-(output,VC) ready, active low.
// release_tail is only honoured for the input that wins the arbiter that cycle.
//
// The locked output is the registered FSM state of every arbiter.
module vc_lock_allocator #(
   parameter int N        = 5,
   parameter int M        = 4,
   parameter int SIZE     = 5,
   parameter int MAX_HOLD = 16,
   parameter int OUT_REG  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N*M*SIZE-1:0]   request,
   input  logic [N*M-1:0]        release_tail,
   input  logic [SIZE*M-1:0]     on_off,
   output logic [N*M-1:0]        grant,
   output logic [N*M*SIZE-1:0]   grant_oh,
   output logic [SIZE*M-1:0]     locked
);

   localparam int OW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   typedef enum logic {IDLE, LOCKED} st_t;

   // Packed views so that [i][j][k] indexing matches the flat port layout.
   logic [N-1:0][M-1:0][SIZE-1:0] req_a;
   logic [N-1:0][M-1:0]            rel_a;
   logic [SIZE-1:0][M-1:0]         on_a;
   logic [N-1:0][M-1:0][SIZE-1:0] gnt_c;
   logic [N-1:0][M-1:0][SIZE-1:0] gnt_v;
   logic [N-1:0][M-1:0][SIZE-1:0] goh_a;
   logic [N-1:0][M-1:0]            grant_a;
   logic [SIZE-1:0][M-1:0]         locked_a;

   st_t           st_q    [SIZE][M];
   st_t           st_n    [SIZE][M];
   logic [OW-1:0] owner_q [SIZE][M];
   logic [OW-1:0] owner_n [SIZE][M];
   logic [OW-1:0] ptr_q   [SIZE][M];
   logic [OW-1:0] ptr_n   [SIZE][M];
   logic [CW-1:0] cnt_q   [SIZE][M];
   logic [CW-1:0] cnt_n   [SIZE][M];

   assign req_a = request;
   assign rel_a = release_tail;
   assign on_a  = on_off;

   // Per-arbiter effective request, round-robin winner, grant and next state.
   always_comb begin : arb_comb
      logic [N-1:0]  req_v;
      logic [N-1:0]  eff;
      logic [N-1:0]  others;
      logic          found;
      logic [OW-1:0] w;
      int            t;
      gnt_c  = '0;
      req_v  = '0;
      eff    = '0;
      others = '0;
      found  = 1'b0;
      w      = '0;
      t      = 0;
      st_n    = st_q;
      owner_n = owner_q;
      ptr_n   = ptr_q;
      cnt_n   = cnt_q;
      for (int k = 0; k < SIZE; k++) begin
         for (int j = 0; j < M; j++) begin
            for (int i = 0; i < N; i++) begin
               req_v[i] = req_a[i][j][k];
            end
            // A live lock narrows the search to the owner; a dead one falls
            // back to the full vector so a new winner is picked this cycle.
            eff = req_v;
            if (st_q[k][j] == LOCKED && req_v[owner_q[k][j]]) begin
               eff = '0;
               eff[owner_q[k][j]] = 1'b1;
            end
            found = 1'b0;
            w     = '0;
            for (int off = 1; off <= N; off++) begin
               t = int'(ptr_q[k][j]) + off;
               if (t >= N) t = t - N;
               if (!found && eff[OW'(t)]) begin
                  found = 1'b1;
                  w     = OW'(t);
               end
            end
            others    = req_v;
            others[w] = 1'b0;
            if (!on_a[k][j]) begin
               if (found) begin
                  gnt_c[w][j][k] = 1'b1;
                  ptr_n[k][j]    = w;
                  if (rel_a[w][j]) begin
                     st_n[k][j]  = IDLE;
                     cnt_n[k][j] = '0;
                  end else if (MAX_HOLD != 0 && cnt_q[k][j] == HOLD_LAST && |others) begin
                     st_n[k][j]  = IDLE;
                     cnt_n[k][j] = '0;
                  end else begin
                     st_n[k][j]    = LOCKED;
                     owner_n[k][j] = w;
                     cnt_n[k][j]   = (cnt_q[k][j] == CNT_MAX) ? cnt_q[k][j]
                                                              : cnt_q[k][j] + 1'b1;
                  end
               end else begin
                  st_n[k][j]  = IDLE;
                  cnt_n[k][j] = '0;
               end
            end
         end
      end
   end

   // Arbiter state registers; reset makes input 0 the first winner everywhere.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SIZE; k++) begin
            for (int j = 0; j < M; j++) begin
               st_q[k][j]    <= IDLE;
               owner_q[k][j] <= '0;
               ptr_q[k][j]   <= OW'(N - 1);
               cnt_q[k][j]   <= '0;
            end
         end
      end else begin
         st_q    <= st_n;
         owner_q <= owner_n;
         ptr_q   <= ptr_n;
         cnt_q   <= cnt_n;
      end
   end

   // No grants leave the block while reset is held.
   assign gnt_v = reset ? '0 : gnt_c;

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [N-1:0][M-1:0][SIZE-1:0] gnt_q;
         // Registered grant stage: same grants, one cycle later.
         always_ff @(posedge clk) begin
            if (reset) gnt_q <= '0;
            else       gnt_q <= gnt_v;
         end
         assign goh_a = gnt_q;
      end else begin : g_out_comb
         assign goh_a = gnt_v;
      end
   endgenerate

   // Per input VC grant summary and per arbiter lock status.
   always_comb begin
      grant_a  = '0;
      locked_a = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < M; j++) begin
            grant_a[i][j] = |goh_a[i][j];
         end
      end
      for (int k = 0; k < SIZE; k++) begin
         for (int j = 0; j < M; j++) begin
            locked_a[k][j] = (st_q[k][j] == LOCKED);
         end
      end
   end

   assign grant_oh = goh_a;
   assign grant    = grant_a;
   assign locked   = locked_a;

endmodule

// File: tb/tb_vc_lock_allocator.sv
// tb_vc_lock_allocator: directed scenarios against two instances sharing the
// same stimulus, one with combinational grants and one with registered grants.
// The driver pushes hand-computed expectations; a negedge monitor pops them.
module tb_vc_lock_allocator;

   localparam int N        = 5;
   localparam int M        = 4;
   localparam int SIZE     = 5;
   localparam int MAX_HOLD = 4;
   localparam int RW       = N * M * SIZE;
   localparam int GW       = N * M;
   localparam int LW       = SIZE * M;

   logic          clk;
   logic          reset;
   logic [RW-1:0] request;
   logic [GW-1:0] release_tail;
   logic [LW-1:0] on_off;

   logic [GW-1:0] grant0, grant1;
   logic [RW-1:0] goh0, goh1;
   logic [LW-1:0] locked0, locked1;

   logic [RW+LW-1:0] exp_q0[$];
   logic [RW+LW-1:0] exp_q1[$];
   logic [RW+LW-1:0] e0, e1;
   logic [RW-1:0]    prev_goh;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   vc_lock_allocator #(
      .N(N), .M(M), .SIZE(SIZE), .MAX_HOLD(MAX_HOLD), .OUT_REG(0)
   ) dut_comb (
      .clk(clk), .reset(reset), .request(request), .release_tail(release_tail),
      .on_off(on_off), .grant(grant0), .grant_oh(goh0), .locked(locked0)
   );

   vc_lock_allocator #(
      .N(N), .M(M), .SIZE(SIZE), .MAX_HOLD(MAX_HOLD), .OUT_REG(1)
   ) dut_reg (
      .clk(clk), .reset(reset), .request(request), .release_tail(release_tail),
      .on_off(on_off), .grant(grant1), .grant_oh(goh1), .locked(locked1)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [RW-1:0] rq(input int i, input int j, input int k);
      logic [RW-1:0] v;
      v = '0;
      v[(i*M+j)*SIZE+k] = 1'b1;
      return v;
   endfunction

   function automatic logic [GW-1:0] rl(input int i, input int j);
      logic [GW-1:0] v;
      v = '0;
      v[i*M+j] = 1'b1;
      return v;
   endfunction

   function automatic logic [LW-1:0] lk(input int k, input int j);
      logic [LW-1:0] v;
      v = '0;
      v[k*M+j] = 1'b1;
      return v;
   endfunction

   function automatic logic [GW-1:0] or_k(input logic [RW-1:0] g);
      logic [GW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < M; j++)
            v[i*M+j] = |g[(i*M+j)*SIZE +: SIZE];
      return v;
   endfunction

   task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %h exp %h", name, cyc, got, exp);
      end
   endtask

   // Driver: apply one cycle of stimulus and queue what each instance must show.
   task automatic drive(input logic rst, input logic [RW-1:0] rq_v,
                        input logic [GW-1:0] rel_v, input logic [LW-1:0] oo_v,
                        input logic [RW-1:0] e_goh, input logic [LW-1:0] e_lk);
      reset        = rst;
      request      = rq_v;
      release_tail = rel_v;
      on_off       = oo_v;
      exp_q0.push_back({e_lk, e_goh});
      exp_q1.push_back({e_lk, prev_goh});
      prev_goh = e_goh;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare both instances mid-cycle against queued expectations.
   always @(negedge clk) begin
      cyc++;
      if (exp_q0.size() > 0) begin
         e0 = exp_q0.pop_front();
         cmp("comb_grant_oh", 128'(goh0),    128'(e0[RW-1:0]));
         cmp("comb_grant",    128'(grant0),  128'(or_k(e0[RW-1:0])));
         cmp("comb_locked",   128'(locked0), 128'(e0[RW+LW-1:RW]));
         for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++)
               if (!$onehot0(request[(i*M+j)*SIZE +: SIZE])) begin
                  errors++;
                  $display("FAIL request_onehot cycle %0d input %0d vc %0d", cyc, i, j);
               end
      end
      if (exp_q1.size() > 0) begin
         e1 = exp_q1.pop_front();
         cmp("reg_grant_oh", 128'(goh1),    128'(e1[RW-1:0]));
         cmp("reg_grant",    128'(grant1),  128'(or_k(e1[RW-1:0])));
         cmp("reg_locked",   128'(locked1), 128'(e1[RW+LW-1:RW]));
      end
   end

   logic [RW-1:0] r_a, p_b, q_g, g_g;
   logic [LW-1:0] l_g;

   initial begin
      reset        = 1'b1;
      request      = '0;
      release_tail = '0;
      on_off       = '0;
      prev_goh     = '0;
      repeat (3) @(posedge clk);
      #1;

      // Reset held with requests present: nothing granted, nothing locked.
      r_a = rq(0,1,2) | rq(3,1,2);
      drive(1, r_a, '0, '0, '0, '0);

      // Arbiter (2,1): input 0 wins first, holds 3 flits, then input 3.
      drive(0, r_a, '0,        '0, rq(0,1,2), '0);
      drive(0, r_a, '0,        '0, rq(0,1,2), lk(2,1));
      drive(0, r_a, rl(0,1),   '0, rq(0,1,2), lk(2,1));
      drive(0, r_a, '0,        '0, rq(3,1,2), '0);
      drive(0, r_a, rl(3,1),   '0, rq(3,1,2), lk(2,1));
      drive(0, '0,  '0,        '0, '0,        '0);

      // Arbiter (4,0): inputs 1 and 2 alternate in runs of MAX_HOLD grants.
      p_b = rq(1,0,4) | rq(2,0,4);
      drive(0, p_b, '0, '0, rq(1,0,4), '0);
      for (int n = 0; n < 3; n++) drive(0, p_b, '0, '0, rq(1,0,4), lk(4,0));
      drive(0, p_b, '0, '0, rq(2,0,4), '0);
      for (int n = 0; n < 3; n++) drive(0, p_b, '0, '0, rq(2,0,4), lk(4,0));
      drive(0, p_b, '0, '0, rq(1,0,4), '0);

      // Back-pressure on (4,0) freezes the lock; hold count resumes after.
      for (int n = 0; n < 3; n++) drive(0, p_b, '0, lk(4,0), '0, lk(4,0));
      for (int n = 0; n < 3; n++) drive(0, p_b, '0, '0, rq(1,0,4), lk(4,0));
      drive(0, p_b, '0, '0, rq(2,0,4), '0);
      drive(0, '0,  '0, '0, '0,        lk(4,0));

      // Arbiter (3,2): owner 0 drops mid-packet, input 2 takes over at once.
      drive(0, rq(0,2,3),             '0,      '0, rq(0,2,3), '0);
      drive(0, rq(0,2,3) | rq(2,2,3), '0,      '0, rq(0,2,3), lk(3,2));
      drive(0, rq(2,2,3),             '0,      '0, rq(2,2,3), lk(3,2));
      drive(0, rq(2,2,3),             rl(2,2), '0, rq(2,2,3), lk(3,2));
      drive(0, '0,                    '0,      '0, '0,        '0);

      // Four arbiters locked, then reset mid-packet; pointers return to N-1.
      q_g = rq(0,0,0) | rq(4,0,0) | rq(1,1,1) | rq(2,2,2) | rq(3,3,3);
      g_g = rq(0,0,0) | rq(1,1,1) | rq(2,2,2) | rq(3,3,3);
      l_g = lk(0,0) | lk(1,1) | lk(2,2) | lk(3,3);
      drive(0, q_g, '0, '0, g_g, '0);
      drive(0, q_g, '0, '0, g_g, l_g);
      drive(1, q_g, '0, '0, '0,  l_g);
      drive(1, q_g, '0, '0, '0,  '0);
      drive(0, q_g, '0, '0, g_g, '0);
      drive(0, '0,  '0, '0, '0,  l_g);
      drive(0, '0,  '0, '0, '0,  '0);

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d/%0d entries left exp 0", exp_q0.size(), exp_q1.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
